// File: rtl/exu_issue_stage.sv
// ID->EX issue register: picks the ALU operands from the decoded instruction and holds them
// in a main register backed by a one-word skid register, so in_ready can stay registered.
module exu_issue_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_pc,
   input  logic [WIDTH-1:0] in_rs1_data,
   input  logic [WIDTH-1:0] in_rs2_data,
   input  logic [WIDTH-1:0] in_imm,
   input  logic [3:0]       in_alu_ctrl,
   input  logic             in_src1_sel,
   input  logic [1:0]       in_src2_sel,
   input  logic [4:0]       in_rd,
   input  logic             in_wen,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   output logic [WIDTH-1:0] out_pc,
   output logic [4:0]       out_rd,
   output logic             out_wen
);

   typedef struct packed {
      logic [3:0]       ctrl;
      logic [WIDTH-1:0] in1;
      logic [WIDTH-1:0] in2;
      logic [WIDTH-1:0] pc;
      logic [4:0]       rd;
      logic             wen;
   } entry_t;

   function automatic logic [WIDTH-1:0] sel_src1(input logic             sel,
                                                 input logic [WIDTH-1:0] rs1,
                                                 input logic [WIDTH-1:0] pc);
      sel_src1 = sel ? pc : rs1;
   endfunction

   function automatic logic [WIDTH-1:0] sel_src2(input logic [1:0]       sel,
                                                 input logic [WIDTH-1:0] rs2,
                                                 input logic [WIDTH-1:0] imm);
      case (sel)
         2'b00:   sel_src2 = rs2;
         2'b01:   sel_src2 = imm;
         2'b10:   sel_src2 = {{(WIDTH-3){1'b0}}, 3'b100};
         default: sel_src2 = '0;
      endcase
   endfunction

   entry_t in_word_p0;
   entry_t main_p1, main_d;
   entry_t skid_p1, skid_d;
   logic   vld_p1, vld_d;
   logic   skid_vld_p1, skid_vld_d;
   logic   in_ready_q;
   logic   accept;
   logic   main_free;

   // Stage p0: operand selection on the incoming IDU word
   always_comb begin
      in_word_p0.ctrl = in_alu_ctrl;
      in_word_p0.in1  = sel_src1(in_src1_sel, in_rs1_data, in_pc);
      in_word_p0.in2  = sel_src2(in_src2_sel, in_rs2_data, in_imm);
      in_word_p0.pc   = in_pc;
      in_word_p0.rd   = in_rd;
      in_word_p0.wen  = in_wen;
   end

   assign accept    = in_valid & in_ready_q;
   assign main_free = ~vld_p1 | out_ready;

   always_comb begin
      main_d     = main_p1;
      skid_d     = skid_p1;
      vld_d      = vld_p1;
      skid_vld_d = skid_vld_p1;
      if (flush) begin
         vld_d      = 1'b0;
         skid_vld_d = 1'b0;
      end else if (main_free) begin
         if (skid_vld_p1) begin
            // Skid is older than anything arriving now, so it moves up first.
            main_d = skid_p1;
            vld_d  = 1'b1;
            if (accept) skid_d = in_word_p0;
            else        skid_vld_d = 1'b0;
         end else begin
            vld_d = accept;
            if (accept) main_d = in_word_p0;
         end
      end else if (accept) begin
         skid_d     = in_word_p0;
         skid_vld_d = 1'b1;
      end
   end

   // Stage p1: main/skid registers feeding the ALU
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_p1     <= '0;
         skid_p1     <= '0;
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         main_p1     <= main_d;
         skid_p1     <= skid_d;
         vld_p1      <= vld_d;
         skid_vld_p1 <= skid_vld_d;
         in_ready_q  <= ~skid_vld_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = vld_p1;
   assign alu_ctrl  = main_p1.ctrl;
   assign alu_in1   = main_p1.in1;
   assign alu_in2   = main_p1.in2;
   assign out_pc    = main_p1.pc;
   assign out_rd    = main_p1.rd;
   assign out_wen   = main_p1.wen;

endmodule

// File: tb/tb_exu_issue_stage.sv
// Bench for exu_issue_stage: random IDU traffic scored against a 2-deep FIFO model.
module tb_exu_issue_stage;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_pc = '0, in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
   logic [3:0]   in_alu_ctrl = '0;
   logic         in_src1_sel = 1'b0;
   logic [1:0]   in_src2_sel = '0;
   logic [4:0]   in_rd = '0;
   logic         in_wen = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [3:0]   alu_ctrl;
   logic [W-1:0] alu_in1, alu_in2, out_pc;
   logic [4:0]   out_rd;
   logic         out_wen;

   exu_issue_stage #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
      .in_alu_ctrl(in_alu_ctrl), .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
      .in_rd(in_rd), .in_wen(in_wen), .out_valid(out_valid), .out_ready(out_ready),
      .alu_ctrl(alu_ctrl), .alu_in1(alu_in1), .alu_in2(alu_in2), .out_pc(out_pc),
      .out_rd(out_rd), .out_wen(out_wen)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   ctrl;
      logic [W-1:0] in1;
      logic [W-1:0] in2;
      logic [W-1:0] pc;
      logic [4:0]   rd;
      logic         wen;
   } exp_t;

   exp_t q[$];
   logic exp_ready = 1'b0;
   logic accepted  = 1'b0;
   int   n_checks  = 0;
   int   n_errors  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t expected_word();
      exp_t e;
      e.ctrl = in_alu_ctrl;
      e.in1  = in_src1_sel ? in_pc : in_rs1_data;
      case (in_src2_sel)
         2'd0: e.in2 = in_rs2_data;
         2'd1: e.in2 = in_imm;
         2'd2: e.in2 = 32'd4;
         default: e.in2 = 32'd0;
      endcase
      e.pc  = in_pc;
      e.rd  = in_rd;
      e.wen = in_wen;
      return e;
   endfunction

   task automatic new_word();
      in_pc       = $urandom;
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      in_imm      = $urandom;
      in_alu_ctrl = 4'($urandom);
      in_src1_sel = 1'($urandom);
      in_src2_sel = 2'($urandom);
      in_rd       = 5'($urandom);
      in_wen      = 1'($urandom);
   endtask

   // The stage is modelled as a FIFO of depth 2 whose ready is registered "not full".
   task automatic compare();
      check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
      check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      if (q.size() > 0) begin
         check("alu_ctrl", {60'd0, alu_ctrl}, {60'd0, q[0].ctrl});
         check("alu_in1", {32'd0, alu_in1}, {32'd0, q[0].in1});
         check("alu_in2", {32'd0, alu_in2}, {32'd0, q[0].in2});
         check("out_pc", {32'd0, out_pc}, {32'd0, q[0].pc});
         check("out_rd", {59'd0, out_rd}, {59'd0, q[0].rd});
         check("out_wen", {63'd0, out_wen}, {63'd0, q[0].wen});
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      accepted = rst_n && !flush && in_valid && exp_ready;
      if (!rst_n) begin
         q.delete();
         exp_ready = 1'b0;
      end else if (flush) begin
         q.delete();
         exp_ready = 1'b1;
      end else begin
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (accepted) q.push_back(expected_word());
         exp_ready = q.size() < 2;
      end
      @(negedge clk);
      compare();
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
   endtask

   initial begin
      int n;
      // 1: reset
      @(negedge clk);
      for (int i = 0; i < 3; i++) cycle();
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_alu_in1", {32'd0, alu_in1}, 64'd0);
      rst_n = 1'b1;
      cycle();
      check("rel_in_ready", {63'd0, in_ready}, 64'd1);

      // 2: operand select
      new_word();
      in_pc = 32'h8000_0000; in_imm = 32'h10; in_src1_sel = 1'b1;
      in_src2_sel = 2'b01; in_alu_ctrl = 4'b0000;
      in_valid = 1'b1; out_ready = 1'b0;
      cycle();
      in_valid = 1'b0;
      check("sel_in1", {32'd0, alu_in1}, 64'h8000_0000);
      check("sel_in2", {32'd0, alu_in2}, 64'h10);
      check("sel_ctrl", {60'd0, alu_ctrl}, 64'd0);
      cycle();
      drain();

      // 3: back-pressure
      n = 0;
      out_ready = 1'b0;
      new_word();
      for (int i = 0; i < 5; i++) begin
         in_valid = (n < 3);
         cycle();
         if (accepted) begin n++; new_word(); end
      end
      check("bp_accepted", 64'(n), 64'd2);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = (n < 3);
         cycle();
         if (accepted) begin n++; new_word(); end
      end
      check("bp_total", 64'(n), 64'd3);
      drain();

      // 4: streaming
      n = 0;
      in_valid = 1'b1; out_ready = 1'b1;
      new_word();
      for (int i = 0; i < 100; i++) begin
         cycle();
         if (accepted) begin n++; new_word(); end
      end
      check("stream_count", 64'(n), 64'd100);
      drain();

      // 5: flush with both entries full
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin new_word(); cycle(); end
      check("fl_full_ready", {63'd0, in_ready}, 64'd0);
      flush = 1'b1; new_word();
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      check("fl_out_valid", {63'd0, out_valid}, 64'd0);
      check("fl_in_ready", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      check("fl_empty", {63'd0, out_valid}, 64'd0);

      // 6: random stalls; the model's head must stay on the outputs while stalled
      new_word();
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         cycle();
         if (accepted) new_word();
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
